// File: rtl/systime_counter.sv
// systime_counter
//
// Owns the 64-bit system time and acts as the timesync master.
//
// Free-running behaviour:
//   - The time advances by one on every clk.
//   - It can instead take a corrected value from the upstream sync
//     command stage.
//
// Timesync behaviour:
//   - timesync_pulse_out toggles on every enabled 2^SYNC_SHIFT boundary.
//   - On request, the time of the next boundary is captured and reported.
//   - timesync_latch_out is then raised for LATCH_HOLD cycles, so every
//     node freezes its capture of that same pulse.
//
// The current-time output is named time_now because "time" is a reserved
// word in SystemVerilog.
//
// Ports:
//   clk                 system clock
//   rst                 synchronous, active-high reset
//   time_load           corrected time value (already compensated)
//   time_load_en        one-cycle strobe: load time_load
//   time_now            current system time (64 bit)
//   systime             time_now[31:0], same cycle
//   sync_en             level: enables boundary detection / pulse toggling
//   sync_latch_req      one-cycle strobe: arm a latch sequence
//   sync_busy           high while a latch sequence is in progress
//   timesync_pulse_out  toggles on each enabled boundary
//   timesync_latch_out  latch level broadcast to all nodes
//   sync_time           master time captured at the latched boundary
//   sync_time_valid     one-cycle strobe: sync_time updated
module systime_counter #(
  parameter int SYNC_SHIFT = 20,
  parameter int LATCH_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] time_load,
  input  logic        time_load_en,
  output logic [63:0] time_now,
  output logic [31:0] systime,
  input  logic        sync_en,
  input  logic        sync_latch_req,
  output logic        sync_busy,
  output logic        timesync_pulse_out,
  output logic        timesync_latch_out,
  output logic [63:0] sync_time,
  output logic        sync_time_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    GAP   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Counter, split into two 32-bit halves.
  //
  // carry_reg is high exactly when lo_reg == 32'hFFFFFFFF. It is set one
  // cycle ahead, from "lo_reg == 32'hFFFFFFFE" while counting, or from the
  // low word of the loaded value on a load.
  //
  // The upper half therefore increments from a registered flag, and no
  // 64-bit carry chain sits in a single path.
  logic [31:0] lo_reg, lo_next;
  logic [31:0] hi_reg, hi_next;
  logic        carry_reg, carry_next;

  always_comb begin
    lo_next    = lo_reg + 32'd1;
    hi_next    = carry_reg ? hi_reg + 32'd1 : hi_reg;
    carry_next = (lo_reg == 32'hFFFF_FFFE);
    if (time_load_en) begin
      lo_next    = time_load[31:0];
      hi_next    = time_load[63:32];
      carry_next = (time_load[31:0] == 32'hFFFF_FFFF);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lo_reg    <= 32'd0;
      hi_reg    <= 32'd0;
      carry_reg <= 1'b0;
    end else begin
      lo_reg    <= lo_next;
      hi_reg    <= hi_next;
      carry_reg <= carry_next;
    end
  end

  assign time_now = {hi_reg, lo_reg};
  assign systime  = lo_reg;

  // Boundary detect on the registered time. It is unaffected by a load in
  // the same cycle, because that load only shows up on the next cycle.
  // SYNC_SHIFT <= 31, so the low word covers the whole compare.
  logic bnd;
  assign bnd = sync_en && (lo_reg[SYNC_SHIFT-1:0] == '0);

  // Pulse toggling is independent of the latch state machine.
  logic pulse_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_reg <= 1'b0;
    end else if (bnd) begin
      pulse_reg <= ~pulse_reg;
    end
  end

  assign timesync_pulse_out = pulse_reg;

  // Latch sequencer
  state_t      state_reg, state_next;
  logic [7:0]  hold_cnt_reg, hold_cnt_next;
  logic [63:0] sync_time_reg;
  logic        valid_reg;
  logic        capture;

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    capture       = 1'b0;
    case (state_reg)
      IDLE: begin
        // A request coinciding with a boundary arms for the following one.
        if (sync_latch_req) begin
          state_next = ARMED;
        end
      end
      ARMED: begin
        if (bnd) begin
          capture    = 1'b1;
          state_next = GAP;
        end
      end
      GAP: begin
        // One dead cycle, so the latch edge follows the pulse edge
        // strictly later.
        state_next    = HOLD;
        hold_cnt_next = 8'(LATCH_HOLD);
      end
      HOLD: begin
        if (hold_cnt_reg <= 8'd1) begin
          state_next    = IDLE;
          hold_cnt_next = 8'd0;
        end else begin
          hold_cnt_next = hold_cnt_reg - 8'd1;
        end
      end
      default: begin
        state_next    = IDLE;
        hold_cnt_next = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      hold_cnt_reg  <= 8'd0;
      sync_time_reg <= 64'd0;
      valid_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      valid_reg    <= capture;
      if (capture) begin
        sync_time_reg <= time_now;
      end
    end
  end

  assign sync_busy          = (state_reg != IDLE);
  assign timesync_latch_out = (state_reg == HOLD);
  assign sync_time          = sync_time_reg;
  assign sync_time_valid    = valid_reg;

endmodule

// File: tb/tb_systime_counter.sv
// Directed bench for systime_counter with SYNC_SHIFT=4, LATCH_HOLD=3.
//
// Expected time and pulse values come from a small reference model. They
// are queued when a cycle's stimulus is driven and popped after the edge.
//
// Latch-sequence expectations are derived from the request time and the
// boundary time the bench expects to be captured.
module tb_systime_counter;

  localparam int SYNC_SHIFT = 4;
  localparam int LATCH_HOLD = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] time_load;
  logic        time_load_en;
  logic [63:0] time_now;
  logic [31:0] systime;
  logic        sync_en;
  logic        sync_latch_req;
  logic        sync_busy;
  logic        timesync_pulse_out;
  logic        timesync_latch_out;
  logic [63:0] sync_time;
  logic        sync_time_valid;

  systime_counter #(
    .SYNC_SHIFT(SYNC_SHIFT),
    .LATCH_HOLD(LATCH_HOLD)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .time_load         (time_load),
    .time_load_en      (time_load_en),
    .time_now          (time_now),
    .systime           (systime),
    .sync_en           (sync_en),
    .sync_latch_req    (sync_latch_req),
    .sync_busy         (sync_busy),
    .timesync_pulse_out(timesync_pulse_out),
    .timesync_latch_out(timesync_latch_out),
    .sync_time         (sync_time),
    .sync_time_valid   (sync_time_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] t;
    logic        p;
  } exp_t;

  exp_t sb[$];

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  logic [63:0] m_time;
  logic        m_pulse;
  logic [63:0] cap_val;

  // Active latch sequence: request cycle time and expected boundary time
  bit          seq_on;
  logic [63:0] req_t;
  logic [63:0] bnd_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_seq_outputs();
    logic [63:0] t;
    logic        e_busy;
    logic        e_latch;
    logic        e_valid;
    t       = m_time;
    e_busy  = seq_on && (t > req_t) && (t <= bnd_t + 1 + LATCH_HOLD);
    e_valid = seq_on && (t == bnd_t + 1);
    e_latch = seq_on && (t >= bnd_t + 2) && (t <= bnd_t + 1 + LATCH_HOLD);
    if (e_valid) begin
      cap_val = bnd_t;
    end
    chk("busy",      {63'd0, sync_busy},          {63'd0, e_busy});
    chk("latch",     {63'd0, timesync_latch_out}, {63'd0, e_latch});
    chk("valid",     {63'd0, sync_time_valid},    {63'd0, e_valid});
    chk("sync_time", sync_time, cap_val);
  endtask

  // One clock cycle.
  //   - Drive the strobes.
  //   - Queue the modelled next time and pulse.
  //   - After the edge, pop the queue and compare.
  task automatic step(input bit ld, input logic [63:0] v, input bit req, input bit r);
    exp_t e;
    rst            = r;
    time_load_en   = ld;
    time_load      = v;
    sync_latch_req = req;
    if (r) begin
      e.t = 64'd0;
      e.p = 1'b0;
    end else begin
      e.t = ld ? v : m_time + 64'd1;
      e.p = (sync_en && (m_time[SYNC_SHIFT-1:0] == '0)) ? ~m_pulse : m_pulse;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e       = sb.pop_front();
    m_time  = e.t;
    m_pulse = e.p;
    chk("time",    time_now, e.t);
    chk("systime", {32'd0, systime}, {32'd0, e.t[31:0]});
    chk("pulse",   {63'd0, timesync_pulse_out}, {63'd0, e.p});
    check_seq_outputs();
    $display("t=%0d time=%h pulse=%b busy=%b latch=%b valid=%b sync_time=%0d",
             $time, time_now, timesync_pulse_out, sync_busy,
             timesync_latch_out, sync_time_valid, sync_time);
    time_load_en   = 1'b0;
    sync_latch_req = 1'b0;
    rst            = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 64'd0, 1'b0, 1'b0);
    end
  endtask

  // Advance until the low nibble of the time equals nib (bounded).
  task automatic run_to_nibble(input logic [3:0] nib);
    for (int i = 0; i < 40 && m_time[3:0] != nib; i++) begin
      step(1'b0, 64'd0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst            = 1'b1;
    time_load      = 64'd0;
    time_load_en   = 1'b0;
    sync_en        = 1'b0;
    sync_latch_req = 1'b0;
    m_time         = 64'd0;
    m_pulse        = 1'b0;
    cap_val        = 64'd0;
    seq_on         = 1'b0;
    req_t          = 64'd0;
    bnd_t          = 64'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_time",      time_now, 64'd0);
    chk("rst_pulse",     {63'd0, timesync_pulse_out}, 64'd0);
    chk("rst_busy",      {63'd0, sync_busy}, 64'd0);
    chk("rst_latch",     {63'd0, timesync_latch_out}, 64'd0);
    chk("rst_valid",     {63'd0, sync_time_valid}, 64'd0);
    chk("rst_sync_time", sync_time, 64'd0);
    rst = 1'b0;

    // Free run with sync disabled: the pulse never toggles.
    run(20);

    // Low-word carry into the upper word, then 64-bit wrap.
    step(1'b1, 64'h0000_0000_FFFF_FFFD, 1'b0, 1'b0);
    run(4);
    step(1'b1, 64'h1234_5678_FFFF_FFFE, 1'b0, 1'b0);
    run(3);
    step(1'b1, 64'h0000_0007_FFFF_FFFF, 1'b0, 1'b0);
    run(2);
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    run(2);

    // Pulse toggling on every 16-cycle boundary.
    sync_en = 1'b1;
    run(50);

    // Load landing on a boundary, then a load jumping over one.
    step(1'b1, 64'h0000_0000_0000_0100, 1'b0, 1'b0);
    run(3);
    step(1'b1, 64'h0000_0000_0000_011E, 1'b0, 1'b0);
    run(4);

    // Latch sequence: request at nibble 5, capture at the next boundary.
    // A second request while busy is ignored.
    run_to_nibble(4'd5);
    seq_on = 1'b1;
    req_t  = m_time;
    bnd_t  = (m_time + 64'd15) & ~64'd15;
    step(1'b0, 64'd0, 1'b1, 1'b0);
    for (int i = 0; i < 40 && m_time != bnd_t + 3; i++) begin
      step(1'b0, 64'd0, 1'b0, 1'b0);
    end
    step(1'b0, 64'd0, 1'b1, 1'b0);
    run(25);

    // Armed with sync disabled: no capture until sync_en rises.
    sync_en = 1'b0;
    run(3);
    req_t = m_time;
    bnd_t = 64'h0000_0100_0000_0000;
    step(1'b0, 64'd0, 1'b1, 1'b0);
    run(100);
    sync_en = 1'b1;
    bnd_t   = (m_time + 64'd15) & ~64'd15;
    run(30);

    // Reset in the middle of HOLD drops the sequence.
    run_to_nibble(4'd9);
    req_t = m_time;
    bnd_t = (m_time + 64'd15) & ~64'd15;
    step(1'b0, 64'd0, 1'b1, 1'b0);
    for (int i = 0; i < 40 && m_time != bnd_t + 3; i++) begin
      step(1'b0, 64'd0, 1'b0, 1'b0);
    end
    chk("mid_hold_latch", {63'd0, timesync_latch_out}, 64'd1);
    seq_on  = 1'b0;
    cap_val = 64'd0;
    step(1'b0, 64'd0, 1'b0, 1'b1);

    // Request at time 0, which is itself a boundary: arms for 16 instead.
    seq_on = 1'b1;
    req_t  = m_time;
    bnd_t  = 64'd16;
    step(1'b0, 64'd0, 1'b1, 1'b0);
    run(25);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
